// File: rtl/jk_mon_pkg.sv
// Purpose: shared types and op codes for JK flip-flop response checking.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: monitor FSM state encoding, {j,k} operation codes.
package jk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HALT  = 2'd2
    } mon_state_t;

    // {j,k} operation codes of a JK flip-flop
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

endpackage

// File: rtl/jk_ref_model.sv
// Purpose: combinational next-state of a JK flip-flop with synchronous reset.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports:
//   i_dut_rst  synchronous reset of the modelled flop (forces next q to 0)
//   i_j, i_k   J and K inputs
//   i_cur_q    current q of the model
//   o_nxt_q    q after the next rising edge
module jk_ref_model
    import jk_mon_pkg::*;
(
    input  logic i_dut_rst,
    input  logic i_j,
    input  logic i_k,
    input  logic i_cur_q,
    output logic o_nxt_q
);

    always_comb begin
        o_nxt_q = i_cur_q;
        if (i_dut_rst) begin
            o_nxt_q = 1'b0;
        end else begin
            case ({i_j, i_k})
                OP_HOLD: o_nxt_q = i_cur_q;
                OP_CLR:  o_nxt_q = 1'b0;
                OP_SET:  o_nxt_q = 1'b1;
                OP_TGL:  o_nxt_q = ~i_cur_q;
                default: o_nxt_q = i_cur_q;
            endcase
        end
    end

endmodule

// File: rtl/jk_ff_monitor.sv
// Purpose: tracks a reference q for an observed jk_ff and flags q/qb departures.
// Latency: err and counters registered at the edge whose sample is compared (visible 1 cycle).
// Backpressure: none; passive observer, samples every rising edge.
// Ports:
//   clk, rst              monitor clock, async active-high monitor reset
//   dut_rst, j, k, q, qb  observed jk_ff reset, inputs and outputs
//   exp_q                 reference q (meaningful in TRACK)
//   err, err_sticky       one-cycle mismatch pulse, latched error flag
//   chk_cnt, err_cnt      saturating comparison / failure counters
//   state                 FSM state (IDLE=0, TRACK=1, HALT=2)
module jk_ff_monitor
    import jk_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dut_rst,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             qb,
    output logic             exp_q,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit               STOP    = (STOP_ON_ERR != 0);

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic             r_exp_q;
    logic             r_err;
    logic             r_err_sticky;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_nxt_q;
    logic             w_mismatch;
    logic             w_do_cmp;
    logic             w_exp_upd;

    jk_ref_model u_ref (
        .i_dut_rst (dut_rst),
        .i_j       (j),
        .i_k       (k),
        .i_cur_q   (r_exp_q),
        .o_nxt_q   (w_nxt_q)
    );

    // Case-inequality so an unknown q or qb is reported as a mismatch in simulation.
    assign w_mismatch = (q !== r_exp_q) || (qb !== ~q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (dut_rst) w_state_nxt = ST_TRACK;
            ST_TRACK: if (STOP && w_mismatch) w_state_nxt = ST_HALT;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes. In IDLE the model is only loaded by dut_rst,
    // which makes it produce 0 and aligns it with the freshly reset DUT.
    always_comb begin
        w_do_cmp  = 1'b0;
        w_exp_upd = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_exp_upd = dut_rst;
            end
            ST_TRACK: begin
                w_do_cmp  = 1'b1;
                w_exp_upd = 1'b1;
            end
            default: begin
                w_do_cmp  = 1'b0;
                w_exp_upd = 1'b0;
            end
        endcase
    end

    // Reference q, error flags and saturating counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_q      <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_chk_cnt    <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_err <= w_do_cmp && w_mismatch;
            if (w_do_cmp) begin
                if (r_chk_cnt != CNT_MAX) r_chk_cnt <= r_chk_cnt + 1'b1;
                if (w_mismatch) begin
                    r_err_sticky <= 1'b1;
                    if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
            if (w_exp_upd) r_exp_q <= w_nxt_q;
        end
    end

    assign exp_q      = r_exp_q;
    assign err        = r_err;
    assign err_sticky = r_err_sticky;
    assign chk_cnt    = r_chk_cnt;
    assign err_cnt    = r_err_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Purpose: self-checking bench for jk_ff_monitor; three monitor variants observe one
//          behavioural jk_ff whose q/qb can be corrupted on demand.
// Latency: outputs checked at the negedge following each rising edge.
// Backpressure: n/a.
module tb_jk_ff_monitor;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst     = 1'b1;
    logic dut_rst = 1'b0;
    logic j       = 1'b0;
    logic k       = 1'b0;
    logic fq_en   = 1'b0;
    logic fq_val  = 1'b0;
    logic qb_bad  = 1'b0;
    logic real_q  = 1'b0;
    logic q_obs;
    logic qb_obs;

    // Behavioural jk_ff being observed
    always @(posedge clk) begin
        if (dut_rst)     real_q <= 1'b0;
        else if (j && k) real_q <= ~real_q;
        else if (j)      real_q <= 1'b1;
        else if (k)      real_q <= 1'b0;
    end

    assign q_obs  = fq_en ? fq_val : real_q;
    assign qb_obs = qb_bad ? q_obs : ~q_obs;

    // Instance 0: CNT_W=8, free-running; 1: CNT_W=2; 2: STOP_ON_ERR=1
    logic       ex0, er0, sk0, ex1, er1, sk1, ex2, er2, sk2;
    logic [1:0] s0, s1, s2;
    logic [7:0] c0, e0, c2, e2;
    logic [1:0] c1, e1;

    jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(0)) u_mon0 (
        .clk(clk), .rst(rst), .dut_rst(dut_rst), .j(j), .k(k), .q(q_obs), .qb(qb_obs),
        .exp_q(ex0), .err(er0), .err_sticky(sk0), .chk_cnt(c0), .err_cnt(e0), .state(s0));
    jk_ff_monitor #(.CNT_W(2), .STOP_ON_ERR(0)) u_mon1 (
        .clk(clk), .rst(rst), .dut_rst(dut_rst), .j(j), .k(k), .q(q_obs), .qb(qb_obs),
        .exp_q(ex1), .err(er1), .err_sticky(sk1), .chk_cnt(c1), .err_cnt(e1), .state(s1));
    jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1)) u_mon2 (
        .clk(clk), .rst(rst), .dut_rst(dut_rst), .j(j), .k(k), .q(q_obs), .qb(qb_obs),
        .exp_q(ex2), .err(er2), .err_sticky(sk2), .chk_cnt(c2), .err_cnt(e2), .state(s2));

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model of each monitor, written from the observable rules:
    // 0=IDLE 1=TRACK 2=HALT, counters clamp at m_max.
    int m_state  [3];
    int m_expq   [3];
    int m_err    [3];
    int m_sticky [3];
    int m_chk    [3];
    int m_errc   [3];
    int m_max    [3] = '{255, 3, 255};
    int m_stop   [3] = '{0, 0, 1};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_state[i] = 0; m_expq[i] = 0; m_err[i] = 0;
            m_sticky[i] = 0; m_chk[i] = 0; m_errc[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                int  cur;
                int  nq;
                bit  bad;
                cur = m_expq[i];
                bad = (int'(q_obs) != cur) || (qb_obs == q_obs);
                if (dut_rst)     nq = 0;
                else if (j && k) nq = 1 - cur;
                else if (j)      nq = 1;
                else if (k)      nq = 0;
                else             nq = cur;
                if (m_state[i] == 0) begin
                    m_err[i] = 0;
                    if (dut_rst) begin m_state[i] = 1; m_expq[i] = 0; end
                end else if (m_state[i] == 1) begin
                    m_chk[i] = (m_chk[i] + 1 > m_max[i]) ? m_max[i] : m_chk[i] + 1;
                    m_err[i] = bad ? 1 : 0;
                    if (bad) begin
                        m_sticky[i] = 1;
                        m_errc[i] = (m_errc[i] + 1 > m_max[i]) ? m_max[i] : m_errc[i] + 1;
                        if (m_stop[i] != 0) m_state[i] = 2;
                    end
                    m_expq[i] = nq;
                end else begin
                    m_err[i] = 0;
                end
            end
        end
    end

    task automatic check_inst(input int i, input int st, input int eq, input int er,
                              input int sk, input int cc, input int ec);
        check_val($sformatf("state[%0d]", i), st, m_state[i]);
        if (m_state[i] != 2) check_val($sformatf("exp_q[%0d]", i), eq, m_expq[i]);
        check_val($sformatf("err[%0d]", i), er, m_err[i]);
        check_val($sformatf("err_sticky[%0d]", i), sk, m_sticky[i]);
        check_val($sformatf("chk_cnt[%0d]", i), cc, m_chk[i]);
        check_val($sformatf("err_cnt[%0d]", i), ec, m_errc[i]);
    endtask

    task automatic check_all();
        check_inst(0, int'(s0), int'(ex0), int'(er0), int'(sk0), int'(c0), int'(e0));
        check_inst(1, int'(s1), int'(ex1), int'(er1), int'(sk1), int'(c1), int'(e1));
        check_inst(2, int'(s2), int'(ex2), int'(er2), int'(sk2), int'(c2), int'(e2));
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
    task automatic step(input logic jj, input logic kk, input logic dr,
                        input logic fe, input logic fv, input logic qbb);
        j = jj; k = kk; dut_rst = dr; fq_en = fe; fq_val = fv; qb_bad = qbb;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Called at a negedge: asynchronous reset must clear outputs before any edge.
    task automatic do_reset();
        dut_rst = 1'b0; fq_en = 1'b0; qb_bad = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("rst_state0", int'(s0), 0);
        check_val("rst_expq0",  int'(ex0), 0);
        check_val("rst_err0",   int'(er0), 0);
        check_val("rst_stk0",   int'(sk0), 0);
        check_val("rst_chk0",   int'(c0), 0);
        check_val("rst_errc0",  int'(e0), 0);
        check_val("rst_state1", int'(s1), 0);
        check_val("rst_stk1",   int'(sk1), 0);
        check_val("rst_errc1",  int'(e1), 0);
        check_val("rst_state2", int'(s2), 0);
        check_val("rst_stk2",   int'(sk2), 0);
        check_val("rst_chk2",   int'(c2), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int t2_j   [5] = '{0, 0, 0, 1, 1};
    int t2_k   [5] = '{0, 1, 0, 0, 1};
    int t2_exp [5] = '{0, 0, 0, 1, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        @(negedge clk);

        // 1: reset, then no dut_rst for 5 cycles
        do_reset();
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val("t1_idle", int'(s0), 0);
            check_val("t1_chk",  int'(c0), 0);
        end

        // 2: arm, then a correct jk_ff through the basic ops
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t2_track", int'(s0), 1);
        check_val("t2_q0",    int'(ex0), 0);
        for (int n = 0; n < 5; n++) begin
            step(1'(t2_j[n]), 1'(t2_k[n]), 1'b0, 1'b0, 1'b0, 1'b0);
            check_val($sformatf("t2_expq%0d", n), int'(ex0), t2_exp[n]);
        end
        check_val("t2_chk",  int'(c0), 5);
        check_val("t2_errc", int'(e0), 0);

        // 3 and 5: clear op, then q forced 1 for one cycle, then 4 toggles
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("t3_err",    int'(er0), 1);
        check_val("t3_stk",    int'(sk0), 1);
        check_val("t3_errc",   int'(e0), 1);
        check_val("t5_halt",   int'(s2), 2);
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_val("t3_pulse", int'(er0), 0);
        end
        check_val("t3_errc_end", int'(e0), 1);
        check_val("t5_state",    int'(s2), 2);
        check_val("t5_errc",     int'(e2), 1);
        check_val("t5_chk",      int'(c2), 7);
        check_val("t5_err",      int'(er2), 0);
        check_val("t5_stk",      int'(sk2), 1);

        // 4: qb equal to q on every TRACK cycle, narrow counters saturate
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_val("t4_err", int'(er1), 1);
        end
        check_val("t4_errc1", int'(e1), 3);
        check_val("t4_chk1",  int'(c1), 3);
        check_val("t4_errc0", int'(e0), 6);
        check_val("t4_stk1",  int'(sk1), 1);

        // 6: reset mid-TRACK with err_sticky set, re-arm and toggle twice
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6_q1", int'(ex0), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t6_q2",   int'(ex0), 0);
        check_val("t6_errc", int'(e0), 0);

        // Randomized traffic with occasional re-sync, faults and resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 29) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
